// File: rtl/branch_redirect_controller.sv
// branch_redirect_controller
// Branch-history table (2-bit saturating counters) for fetch prediction,
// trained by resolved branches from execute. A mispredict starts a held
// redirect/flush handshake toward fetch, decode and execute.
// Optional build macro: BRANCH_PERF_EN adds saturating branch and mispredict
// counters; without it both counter outputs are tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | normal flow, control outputs low, branches train and detect
// REDIRECT | redirect/flush/kill asserted, held until FetchReady_I is high
module branch_redirect_controller #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC_I,
  output logic            PredictTaken_I,
  input  logic            FetchReady_I,
  input  logic            BranchValid_C,
  input  logic            BranchTaken_C,
  input  logic            PredictedTaken_C,
  input  logic [XLEN-1:0] BranchPC_C,
  input  logic [XLEN-1:0] BranchTarget_C,
  input  logic            Stall_C,
  output logic            Redirect_I,
  output logic [XLEN-1:0] RedirectPC_I,
  output logic            FlushF_I,
  output logic            FlushD_I,
  output logic            KillE_C,
  output logic [31:0]     BranchCount_C,
  output logic [31:0]     MispredictCount_C
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [1:0]              bht [ENTRIES];
  logic [INDEX_BITS-1:0]   fetch_idx;
  logic [INDEX_BITS-1:0]   branch_idx;
  logic                    train;
  logic                    mispredict;
  logic [XLEN-1:0]         correct_pc;
  logic                    unused_pc_bits;

  assign fetch_idx      = PC_I[INDEX_BITS+1:2];
  assign branch_idx     = BranchPC_C[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{PC_I[XLEN-1:INDEX_BITS+2], PC_I[1:0]};

  // Read is asynchronous, so a same-cycle write to this index is seen next cycle.
  assign PredictTaken_I = bht[fetch_idx][1];

  // KillE_C is exactly "state is REDIRECT"; testing state directly keeps the
  // kill qualifier out of a loop through the output decode.
  assign train      = BranchValid_C & ~Stall_C & (state_q == IDLE);
  assign mispredict = train & (BranchTaken_C != PredictedTaken_C);
  assign correct_pc = BranchTaken_C ? BranchTarget_C : BranchPC_C + XLEN'(4);

  // BHT counters: saturating increment on taken, decrement on not taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (train) begin
      if (BranchTaken_C && bht[branch_idx] != 2'b11)
        bht[branch_idx] <= bht[branch_idx] + 2'b01;
      else if (!BranchTaken_C && bht[branch_idx] != 2'b00)
        bht[branch_idx] <= bht[branch_idx] - 2'b01;
    end
  end

  // State register and redirect address capture on mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      RedirectPC_I <= '0;
    end else begin
      state_q <= state_d;
      if (mispredict) RedirectPC_I <= correct_pc;
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    state_d    = state_q;
    Redirect_I = 1'b0;
    FlushF_I   = 1'b0;
    FlushD_I   = 1'b0;
    KillE_C    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mispredict) state_d = REDIRECT;
      end
      REDIRECT: begin
        Redirect_I = 1'b1;
        FlushF_I   = 1'b1;
        FlushD_I   = 1'b1;
        KillE_C    = 1'b1;
        if (FetchReady_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (train && branch_count_q != 32'hFFFF_FFFF)
        branch_count_q <= branch_count_q + 32'd1;
      if (mispredict && mispredict_count_q != 32'hFFFF_FFFF)
        mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign BranchCount_C     = branch_count_q;
  assign MispredictCount_C = mispredict_count_q;
`else
  assign BranchCount_C     = '0;
  assign MispredictCount_C = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Directed bench for branch_redirect_controller; expected values hand-derived.
// Entries touched: PCs 0x100/0x200/0x300/0x400 share BHT index 0,
// 0x40 is index 0x10, 0xFFFFFFFC is index 0x3F.
module tb_branch_redirect_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_I = '0;
  logic        PredictTaken_I;
  logic        FetchReady_I = 1'b0;
  logic        BranchValid_C = 1'b0;
  logic        BranchTaken_C = 1'b0;
  logic        PredictedTaken_C = 1'b0;
  logic [31:0] BranchPC_C = '0;
  logic [31:0] BranchTarget_C = '0;
  logic        Stall_C = 1'b0;
  logic        Redirect_I;
  logic [31:0] RedirectPC_I;
  logic        FlushF_I;
  logic        FlushD_I;
  logic        KillE_C;
  logic [31:0] BranchCount_C;
  logic [31:0] MispredictCount_C;

  int n_checks = 0;
  int n_fail   = 0;

  branch_redirect_controller #(.XLEN(32), .INDEX_BITS(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .PC_I             (PC_I),
    .PredictTaken_I   (PredictTaken_I),
    .FetchReady_I     (FetchReady_I),
    .BranchValid_C    (BranchValid_C),
    .BranchTaken_C    (BranchTaken_C),
    .PredictedTaken_C (PredictedTaken_C),
    .BranchPC_C       (BranchPC_C),
    .BranchTarget_C   (BranchTarget_C),
    .Stall_C          (Stall_C),
    .Redirect_I       (Redirect_I),
    .RedirectPC_I     (RedirectPC_I),
    .FlushF_I         (FlushF_I),
    .FlushD_I         (FlushD_I),
    .KillE_C          (KillE_C),
    .BranchCount_C    (BranchCount_C),
    .MispredictCount_C(MispredictCount_C)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All four control outputs packed as {Redirect, FlushF, FlushD, KillE}.
  function automatic logic [31:0] ctl();
    return {28'd0, Redirect_I, FlushF_I, FlushD_I, KillE_C};
  endfunction

  task automatic branch(input logic [31:0] pc, input logic taken, input logic pred,
                        input logic [31:0] target);
    BranchValid_C    = 1'b1;
    BranchPC_C       = pc;
    BranchTaken_C    = taken;
    PredictedTaken_C = pred;
    BranchTarget_C   = target;
  endtask

  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctl", ctl(), 32'h0);
    check_eq("rst_rpc", RedirectPC_I, 32'h0);
    check_eq("rst_bc", BranchCount_C, 32'h0);
    check_eq("rst_mc", MispredictCount_C, 32'h0);
    #3 reset = 1'b1;
    tick();
    PC_I = 32'h100;
    #1 check_eq("pred_rst_0x100", {31'd0, PredictTaken_I}, 32'd0);

    // Four taken at 0x100: 01->10->11->11->11 ; same-cycle read is pre-write
    branch(32'h100, 1'b1, 1'b1, 32'h500);
    #1 check_eq("pred_prewrite", {31'd0, PredictTaken_I}, 32'd0);
    tick();
    check_eq("pred_after_1t", {31'd0, PredictTaken_I}, 32'd1);
    repeat (3) tick();
    check_eq("pred_after_4t", {31'd0, PredictTaken_I}, 32'd1);
    check_eq("no_redir_train", ctl(), 32'h0);
    // Not taken: 11->10 (still 1), 10->01 (0), 01->00
    branch(32'h100, 1'b0, 1'b0, 32'h500);
    tick();
    check_eq("pred_sat_10", {31'd0, PredictTaken_I}, 32'd1);
    tick();
    check_eq("pred_01", {31'd0, PredictTaken_I}, 32'd0);
    tick();
    BranchValid_C = 1'b0;
    // 7 training events, 0 mispredicts so far

    // Mispredict at 0x200 (idx 0): predicted taken, not taken, FetchReady high
    FetchReady_I = 1'b1;
    branch(32'h200, 1'b0, 1'b1, 32'h900);
    tick();
    BranchValid_C = 1'b0;
    check_eq("mp1_ctl", ctl(), 32'hF);
    check_eq("mp1_rpc", RedirectPC_I, 32'h204);
    tick();
    check_eq("mp1_done", ctl(), 32'h0);
    check_eq("mp1_rpc_keep", RedirectPC_I, 32'h204);

    // Mispredict at 0x300 (idx 0, 00->01): predicted not-taken, taken to 0x80
    FetchReady_I = 1'b0;
    branch(32'h300, 1'b1, 1'b0, 32'h80);
    tick();
    // Wrong-path mispredict pattern during the hold at 0x40 (idx 0x10)
    branch(32'h40, 1'b1, 1'b0, 32'h999);
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_ctl", ctl(), 32'hF);
      check_eq("hold_rpc", RedirectPC_I, 32'h80);
      tick();
    end
    FetchReady_I = 1'b1;
    check_eq("hold_last_ctl", ctl(), 32'hF);
    tick();
    BranchValid_C = 1'b0;
    check_eq("hold_release", ctl(), 32'h0);
    check_eq("hold_rpc_final", RedirectPC_I, 32'h80);
    PC_I = 32'h40;
    #1 check_eq("hold_no_train", {31'd0, PredictTaken_I}, 32'd0);
    PC_I = 32'h100;
    #1 check_eq("idx0_after_sat0", {31'd0, PredictTaken_I}, 32'd0);

    // Wraparound of the fall-through address
    branch(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1000);
    tick();
    BranchValid_C = 1'b0;
    check_eq("wrap_ctl", ctl(), 32'hF);
    check_eq("wrap_rpc", RedirectPC_I, 32'h0);
    tick();
    check_eq("wrap_done", ctl(), 32'h0);
`ifdef BRANCH_PERF_EN
    exp_bc = 32'd10; exp_mc = 32'd3;
`else
    exp_bc = 32'd0;  exp_mc = 32'd0;
`endif
    check_eq("bcount_10", BranchCount_C, exp_bc);
    check_eq("mcount_3", MispredictCount_C, exp_mc);

    // Stalled mispredict: nothing until the stall drops
    Stall_C = 1'b1;
    FetchReady_I = 1'b0;
    branch(32'h400, 1'b1, 1'b0, 32'h1234);
    tick();
    check_eq("stall_ctl_a", ctl(), 32'h0);
    tick();
    check_eq("stall_ctl_b", ctl(), 32'h0);
    check_eq("stall_rpc", RedirectPC_I, 32'h0);
    check_eq("stall_no_train", {31'd0, PredictTaken_I}, 32'd0);
    Stall_C = 1'b0;
    tick();
    BranchValid_C = 1'b0;
    check_eq("unstall_ctl", ctl(), 32'hF);
    check_eq("unstall_rpc", RedirectPC_I, 32'h1234);
    check_eq("unstall_pred", {31'd0, PredictTaken_I}, 32'd1);
`ifdef BRANCH_PERF_EN
    exp_bc = 32'd11; exp_mc = 32'd4;
`endif
    check_eq("bcount_stall", BranchCount_C, exp_bc);
    check_eq("mcount_stall", MispredictCount_C, exp_mc);

    // Asynchronous reset in the middle of REDIRECT
    tick();
    check_eq("pre_rst_ctl", ctl(), 32'hF);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_ctl", ctl(), 32'h0);
    check_eq("mid_rst_rpc", RedirectPC_I, 32'h0);
    check_eq("mid_rst_bht", {31'd0, PredictTaken_I}, 32'd0);
    check_eq("mid_rst_bc", BranchCount_C, 32'h0);
    check_eq("mid_rst_mc", MispredictCount_C, 32'h0);
    #2 reset = 1'b1;
    tick();
    check_eq("post_rst_ctl_a", ctl(), 32'h0);
    tick();
    check_eq("post_rst_ctl_b", ctl(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
